// File: rtl/dm_mw_stage_pkg.sv
// Shared memory-access encodings for the M stage and the downstream load extender.
package dm_mw_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned LANES  = XLEN / 8;

  localparam logic [2:0] MR_NONE = 3'b000;
  localparam logic [2:0] MR_B    = 3'b010;
  localparam logic [2:0] MR_BU   = 3'b011;
  localparam logic [2:0] MR_H    = 3'b100;
  localparam logic [2:0] MR_HU   = 3'b101;
  localparam logic [2:0] MR_W    = 3'b110;

  typedef enum logic [1:0] {
    MW_NONE = 2'b00,
    MW_B    = 2'b01,
    MW_H    = 2'b10,
    MW_W    = 2'b11
  } mw_e;

  function automatic logic is_load_code(input logic [2:0] mr);
    return (mr == MR_B) || (mr == MR_BU) || (mr == MR_H) || (mr == MR_HU) || (mr == MR_W);
  endfunction

  // Alignment fault for a load of the given code at byte offset lo.
  function automatic logic load_misaligned(input logic [2:0] mr, input logic [1:0] lo);
    if (mr == MR_H || mr == MR_HU) return lo[0];
    if (mr == MR_W)                return lo != 2'b00;
    return 1'b0;
  endfunction

endpackage

// File: rtl/dm_mw_stage_if.sv
// M-side request and W-side result bundle of the memory stage.
interface dm_mw_stage_if;
  import dm_mw_stage_pkg::*;

  logic [XLEN-1:0] ALUOut_M;
  logic [XLEN-1:0] WriteData_M;
  logic [1:0]      MemWrite_M;
  logic [2:0]      MemRead_M;

  logic [XLEN-1:0] DM_W;
  logic [XLEN-1:0] ALUOut_W;
  logic [2:0]      MemRead_W;
  logic            AdEL_W;
  logic            AdES_W;

  modport master (
    output ALUOut_M, WriteData_M, MemWrite_M, MemRead_M,
    input  DM_W, ALUOut_W, MemRead_W, AdEL_W, AdES_W
  );

  modport slave (
    input  ALUOut_M, WriteData_M, MemWrite_M, MemRead_M,
    output DM_W, ALUOut_W, MemRead_W, AdEL_W, AdES_W
  );
endinterface

// File: rtl/dm_store_align.sv
// Store lane steering: byte enables, lane-replicated write data and store fault.
module dm_store_align
  import dm_mw_stage_pkg::*;
(
  input  logic [1:0]       mem_write,
  input  logic [1:0]       addr_lo,
  input  logic [XLEN-1:0]  wdata_in,
  input  logic             in_range,
  output logic [LANES-1:0] be_c,
  output logic [XLEN-1:0]  wdata_c,
  output logic             ades_c
);

  logic [LANES-1:0] be_raw;
  logic             misaligned;

  always_comb begin
    be_raw     = '0;
    wdata_c    = wdata_in;
    misaligned = 1'b0;
    case (mw_e'(mem_write))
      MW_B: begin
        be_raw  = LANES'(1) << addr_lo;
        wdata_c = {4{wdata_in[7:0]}};
      end
      MW_H: begin
        be_raw     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_c    = {2{wdata_in[15:0]}};
        misaligned = addr_lo[0];
      end
      MW_W: begin
        be_raw     = 4'b1111;
        misaligned = addr_lo != 2'b00;
      end
      default: ;
    endcase
  end

  // A faulting store must leave memory untouched, so its enables are squashed.
  assign ades_c = (mem_write != 2'b00) && (!in_range || misaligned);
  assign be_c   = ades_c ? '0 : be_raw;

endmodule

// File: rtl/dm_mw_stage.sv
// Memory stage: word-organised data memory plus the M/W pipeline register.
module dm_mw_stage
  import dm_mw_stage_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic         clk,
  input  logic         reset,
  dm_mw_stage_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [XLEN-1:0]  mem_q [DEPTH_WORDS];

  logic [29:0]      word_idx;
  logic [IDX_W-1:0] mem_idx;
  logic             in_range;
  logic [XLEN-1:0]  rd_word;
  logic             load_req;
  logic             load_ok;

  logic [LANES-1:0] be;
  logic [XLEN-1:0]  wdata;
  logic             ades;

  logic [XLEN-1:0]  dm_d, dm_q;
  logic [XLEN-1:0]  alu_d, alu_q;
  logic [2:0]       mr_d, mr_q;
  logic             adel_d, adel_q;
  logic             ades_d, ades_q;

  assign word_idx = bus.ALUOut_M[31:2];
  assign in_range = word_idx < 30'(DEPTH_WORDS);
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign rd_word  = in_range ? mem_q[mem_idx] : '0;

  dm_store_align u_align (
    .mem_write (bus.MemWrite_M),
    .addr_lo   (bus.ALUOut_M[1:0]),
    .wdata_in  (bus.WriteData_M),
    .in_range  (in_range),
    .be_c      (be),
    .wdata_c   (wdata),
    .ades_c    (ades)
  );

  // Data memory; reset clears every word so an aborted store leaves no trace.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (be[l]) mem_q[mem_idx][8*l +: 8] <= wdata[8*l +: 8];
      end
    end
  end

  assign load_req = is_load_code(bus.MemRead_M);
  assign load_ok  = load_req && in_range && !load_misaligned(bus.MemRead_M, bus.ALUOut_M[1:0]);

  // M/W register inputs; the read sees the pre-write word (no forwarding).
  always_comb begin
    dm_d   = rd_word;
    alu_d  = bus.ALUOut_M;
    mr_d   = bus.MemRead_M;
    adel_d = 1'b0;
    ades_d = ades;
    if (load_req && !load_ok) begin
      dm_d   = '0;
      mr_d   = MR_NONE;
      adel_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dm_q   <= '0;
      alu_q  <= '0;
      mr_q   <= MR_NONE;
      adel_q <= 1'b0;
      ades_q <= 1'b0;
    end else begin
      dm_q   <= dm_d;
      alu_q  <= alu_d;
      mr_q   <= mr_d;
      adel_q <= adel_d;
      ades_q <= ades_d;
    end
  end

  assign bus.DM_W      = dm_q;
  assign bus.ALUOut_W  = alu_q;
  assign bus.MemRead_W = mr_q;
  assign bus.AdEL_W    = adel_q;
  assign bus.AdES_W    = ades_q;

endmodule

// File: tb/tb_dm_mw_stage.sv
// Directed and randomized checks of dm_mw_stage against a byte-level memory model.
module tb_dm_mw_stage;

  localparam int DEPTH = 4096;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] mdl [DEPTH];

  dm_mw_stage_if bus ();

  dm_mw_stage #(.DEPTH_WORDS(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] dm, input logic [31:0] alu,
                       input logic [2:0] mr, input logic adel, input logic ades);
    chk({tag, ".DM_W"},      bus.DM_W,              dm);
    chk({tag, ".ALUOut_W"},  bus.ALUOut_W,          alu);
    chk({tag, ".MemRead_W"}, 32'(bus.MemRead_W),    32'(mr));
    chk({tag, ".AdEL_W"},    32'(bus.AdEL_W),       32'(adel));
    chk({tag, ".AdES_W"},    32'(bus.AdES_W),       32'(ades));
  endtask

  function automatic bit is_load(input logic [2:0] mr);
    return mr inside {3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
  endfunction

  // One cycle: drive at negedge, predict from the model, check #1 after the edge.
  task automatic step(input string tag, input logic [1:0] mw, input logic [2:0] mr,
                      input logic [31:0] a, input logic [31:0] d);
    longint unsigned idx;
    bit              inr, st_ok, ld_ok;
    int              off;
    logic [31:0]     e_dm, e_alu, w;
    logic [2:0]      e_mr;
    logic            e_adel, e_ades;
    idx = longint'(a) / 4;
    off = int'(a % 4);
    inr = idx < DEPTH;
    case (mw)
      2'd1:    st_ok = inr;
      2'd2:    st_ok = inr && (off % 2 == 0);
      2'd3:    st_ok = inr && (off == 0);
      default: st_ok = 1'b0;
    endcase
    case (mr)
      3'b100, 3'b101: ld_ok = inr && (off % 2 == 0);
      3'b110:         ld_ok = inr && (off == 0);
      default:        ld_ok = inr;
    endcase
    e_alu  = a;
    e_ades = (mw != 2'd0) && !st_ok;
    if (is_load(mr) && !ld_ok) begin
      e_dm = 32'h0; e_mr = 3'b000; e_adel = 1'b1;
    end else begin
      e_dm = inr ? mdl[idx] : 32'h0; e_mr = mr; e_adel = 1'b0;
    end
    if (st_ok) begin
      w = mdl[idx];
      case (mw)
        2'd1:    w[8*off +: 8]  = d[7:0];
        2'd2:    w[8*off +: 16] = d[15:0];
        default: w = d;
      endcase
      mdl[idx] = w;
    end
    bus.MemWrite_M  = mw;
    bus.MemRead_M   = mr;
    bus.ALUOut_M    = a;
    bus.WriteData_M = d;
    @(posedge clk);
    #1;
    chk_w(tag, e_dm, e_alu, e_mr, e_adel, e_ades);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    bus.MemWrite_M  = 2'd0;
    bus.MemRead_M   = 3'b000;
    bus.ALUOut_M    = 32'h0;
    bus.WriteData_M = 32'h0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_w("reset", 32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Store/load round trips.
    step("sw100",   2'd3, 3'b000, 32'h100, 32'hDEADBEEF);
    step("lw100",   2'd0, 3'b110, 32'h100, 32'h0);
    step("sw100b",  2'd3, 3'b000, 32'h100, 32'h11223344);
    step("sb103",   2'd1, 3'b000, 32'h103, 32'h000000A5);
    step("lw100c",  2'd0, 3'b110, 32'h100, 32'h0);
    step("sh102",   2'd2, 3'b000, 32'h102, 32'h0000BEEF);
    step("lhu102",  2'd0, 3'b101, 32'h102, 32'h0);
    step("lb101",   2'd0, 3'b010, 32'h101, 32'h0);

    // Store faults leave memory unchanged.
    step("sh101",   2'd2, 3'b000, 32'h101, 32'h0000FFFF);
    step("sw4000",  2'd3, 3'b000, 32'h4000, 32'hFFFFFFFF);
    step("lw100d",  2'd0, 3'b110, 32'h100, 32'h0);
    step("lw3ffc",  2'd0, 3'b110, 32'h3FFC, 32'h0);
    step("lb4000",  2'd0, 3'b010, 32'h4000, 32'h0);

    // Same-cycle read/write of one word returns the old value.
    step("swlw20",  2'd3, 3'b110, 32'h20, 32'h12345678);
    step("lw20",    2'd0, 3'b110, 32'h20, 32'h0);
    step("lw22",    2'd0, 3'b110, 32'h22, 32'h0);
    step("lh21",    2'd0, 3'b100, 32'h21, 32'h0);
    step("nold21",  2'd0, 3'b000, 32'h21, 32'h0);

    // Async reset mid-access with a store pending.
    step("sw10",    2'd3, 3'b000, 32'h10, 32'h00000055);
    bus.MemWrite_M  = 2'd3;
    bus.MemRead_M   = 3'b110;
    bus.ALUOut_M    = 32'h10;
    bus.WriteData_M = 32'hCAFEF00D;
    #2 reset = 1'b1;
    #1;
    chk_w("rst_async", 32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_w("rst_hold", 32'h0, 32'h0, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    step("lw10rst", 2'd0, 3'b110, 32'h10, 32'h0);
    step("lw100rst",2'd0, 3'b110, 32'h100, 32'h0);

    // Randomized mix over a small window plus out-of-range addresses.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      int unsigned r;
      r = $urandom_range(0, 19);
      if (r == 0)      a = 32'((DEPTH + int'($urandom_range(0, 3))) * 4 + int'($urandom_range(0, 3)));
      else if (r == 1) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else             a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      step("rand", 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), a, $urandom);
    end
    for (int i = 0; i < 16; i++) step("sweep", 2'd0, 3'b110, 32'(i * 4), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
